// File: rtl/decoder_scan_n.sv
// Registered one-cold decoder with active-low enable and outputs. Direct mode
// decodes sel; scan mode walks every output with a programmable dwell and a blanking gap.
module decoder_scan_n #(
  parameter int SEL_W   = 2,
  parameter int NUM_OUT = 4,
  parameter int DWELL_W = 8,
  parameter int BLANK   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_n,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic [DWELL_W-1:0] dwell,
  output logic [NUM_OUT-1:0] y,
  output logic [SEL_W-1:0]   idx,
  output logic               wrap
);

  localparam int BLIM = (BLANK > 0) ? BLANK - 1 : 0;
  localparam int BW   = (BLIM > 0) ? $clog2(BLIM + 1) : 1;

  typedef enum logic {S_DRIVE, S_BLANK} state_t;

  state_t             r_state;
  logic [NUM_OUT-1:0] r_y;
  logic [SEL_W-1:0]   r_idx;
  logic               r_wrap;
  logic [DWELL_W-1:0] r_cnt;
  logic [BW-1:0]      r_bcnt;

  logic [DWELL_W-1:0] w_dm1;
  logic               w_dlast;
  logic               w_blast;
  logic               w_nwrap;
  logic [SEL_W-1:0]   w_nidx;

  // Out-of-range codes decode to all-inactive.
  function automatic logic [NUM_OUT-1:0] dec(input logic [SEL_W-1:0] i);
    logic [NUM_OUT-1:0] d;
    for (int k = 0; k < NUM_OUT; k++) d[k] = (i != SEL_W'(k));
    return d;
  endfunction

  // dwell of 0 behaves as 1; >= rather than == so a shrunk dwell ends the position at once.
  assign w_dm1   = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
  assign w_dlast = (r_cnt >= w_dm1);
  assign w_blast = (r_bcnt >= BW'(BLIM));
  assign w_nwrap = (r_idx >= SEL_W'(NUM_OUT - 1));
  assign w_nidx  = w_nwrap ? '0 : r_idx + SEL_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_DRIVE;
      r_y     <= '1;
      r_idx   <= '0;
      r_wrap  <= 1'b0;
      r_cnt   <= '0;
      r_bcnt  <= '0;
    end else if (en_n) begin
      r_y    <= '1;
      r_wrap <= 1'b0;
    end else if (!mode) begin
      r_state <= S_DRIVE;
      r_idx   <= sel;
      r_cnt   <= '0;
      r_bcnt  <= '0;
      r_wrap  <= 1'b0;
      r_y     <= dec(sel);
    end else begin
      case (r_state)
        S_DRIVE: begin
          if (!w_dlast) begin
            r_cnt  <= r_cnt + DWELL_W'(1);
            r_wrap <= 1'b0;
            r_y    <= dec(r_idx);
          end else begin
            r_cnt <= '0;
            if (BLANK > 0) begin
              r_state <= S_BLANK;
              r_bcnt  <= '0;
              r_wrap  <= 1'b0;
              r_y     <= '1;
            end else begin
              r_idx  <= w_nidx;
              r_wrap <= w_nwrap;
              r_y    <= dec(w_nidx);
            end
          end
        end
        S_BLANK: begin
          if (w_blast) begin
            r_state <= S_DRIVE;
            r_bcnt  <= '0;
            r_idx   <= w_nidx;
            r_wrap  <= w_nwrap;
            r_y     <= dec(w_nidx);
          end else begin
            r_bcnt <= r_bcnt + BW'(1);
            r_wrap <= 1'b0;
            r_y    <= '1;
          end
        end
        default: begin
          r_state <= S_DRIVE;
          r_y     <= '1;
          r_wrap  <= 1'b0;
        end
      endcase
    end
  end

  assign y    = r_y;
  assign idx  = r_idx;
  assign wrap = r_wrap;

endmodule

// File: tb/tb_decoder_scan_n.sv
// Bench for decoder_scan_n: two configurations checked every cycle against a
// slot-based model, plus literal sequences for reset, direct decode, scan and freeze.
module tb_decoder_scan_n;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       chk_en = 1'b0;
  int         total = 0;
  int         bad = 0;

  // Instance A: SEL_W=2, NUM_OUT=4, DWELL_W=8, BLANK=1
  logic       a_en_n, a_mode, a_wrap;
  logic [1:0] a_sel, a_idx;
  logic [7:0] a_dwell;
  logic [3:0] a_y;
  // Instance B: SEL_W=3, NUM_OUT=5, DWELL_W=4, BLANK=0
  logic       b_en_n, b_mode, b_wrap;
  logic [2:0] b_sel, b_idx;
  logic [3:0] b_dwell;
  logic [4:0] b_y;

  decoder_scan_n #(.SEL_W(2), .NUM_OUT(4), .DWELL_W(8), .BLANK(1)) u_a (
    .clk(clk), .rst_n(rst_n), .en_n(a_en_n), .mode(a_mode), .sel(a_sel),
    .dwell(a_dwell), .y(a_y), .idx(a_idx), .wrap(a_wrap));

  decoder_scan_n #(.SEL_W(3), .NUM_OUT(5), .DWELL_W(4), .BLANK(0)) u_b (
    .clk(clk), .rst_n(rst_n), .en_n(b_en_n), .mode(b_mode), .sel(b_sel),
    .dwell(b_dwell), .y(b_y), .idx(b_idx), .wrap(b_wrap));

  always #5 clk = ~clk;

  // Model: position idx, whether we are in the gap, and cycles spent in the current phase.
  typedef struct {
    int idx;
    bit gap;
    int k;
    int y;
    bit wrap;
  } mst_t;

  function automatic mst_t mreset(input int nout);
    mst_t s;
    s.idx = 0; s.gap = 1'b0; s.k = 0; s.y = (1 << nout) - 1; s.wrap = 1'b0;
    return s;
  endfunction

  function automatic mst_t mstep(input mst_t s, input int nout, input int blank,
                                 input bit en_n, input bit mode, input int sel, input int dwell);
    mst_t n;
    int d;
    int all;
    bit adv;
    n = s;
    all = (1 << nout) - 1;
    d = (dwell == 0) ? 1 : dwell;
    adv = 1'b0;
    n.wrap = 1'b0;
    if (en_n) begin
      n.y = all;
      return n;
    end
    if (!mode) begin
      n.idx = sel; n.gap = 1'b0; n.k = 0;
    end else if (!s.gap) begin
      if (s.k + 1 < d) n.k = s.k + 1;
      else begin
        n.k = 0;
        if (blank > 0) n.gap = 1'b1;
        else adv = 1'b1;
      end
    end else begin
      if (s.k + 1 < blank) n.k = s.k + 1;
      else begin
        n.k = 0; n.gap = 1'b0; adv = 1'b1;
      end
    end
    if (adv) begin
      n.wrap = (s.idx >= nout - 1);
      n.idx  = n.wrap ? 0 : s.idx + 1;
    end
    n.y = (n.gap || n.idx >= nout) ? all : (all ^ (1 << n.idx));
    return n;
  endfunction

  mst_t ma, mb;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma <= mreset(4);
      mb <= mreset(5);
    end else begin
      ma <= mstep(ma, 4, 1, a_en_n, a_mode, int'(a_sel), int'(a_dwell));
      mb <= mstep(mb, 5, 0, b_en_n, b_mode, int'(b_sel), int'(b_dwell));
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h want=%0h", nm, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("A.y",    int'(a_y),    ma.y);
      chk("A.idx",  int'(a_idx),  ma.idx);
      chk("A.wrap", int'(a_wrap), int'(ma.wrap));
      chk("B.y",    int'(b_y),    mb.y);
      chk("B.idx",  int'(b_idx),  mb.idx);
      chk("B.wrap", int'(b_wrap), int'(mb.wrap));
    end
  end

  logic [3:0] dir4 [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [3:0] scan4 [17] = '{4'b1110, 4'b1110, 4'b1110, 4'b1111,
                             4'b1101, 4'b1101, 4'b1101, 4'b1111,
                             4'b1011, 4'b1011, 4'b1011, 4'b1111,
                             4'b0111, 4'b0111, 4'b0111, 4'b1111, 4'b1110};
  logic [4:0] scan5 [5] = '{5'b11110, 5'b11101, 5'b11011, 5'b10111, 5'b01111};

  initial begin
    a_en_n = 1'b1; a_mode = 1'b0; a_sel = '0; a_dwell = '0;
    b_en_n = 1'b1; b_mode = 1'b0; b_sel = '0; b_dwell = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("A.rst_y", int'(a_y), 4'hF);
    chk("A.rst_idx", int'(a_idx), 0);
    @(negedge clk);
    chk_en = 1'b1;

    // Direct decode of every code, then disable.
    a_en_n = 1'b0;
    for (int s = 0; s < 4; s++) begin
      a_sel = 2'(s);
      @(negedge clk);
      chk("A.direct", int'(a_y), int'(dir4[s]));
    end
    a_en_n = 1'b1;
    @(negedge clk);
    chk("A.disabled", int'(a_y), 4'hF);

    // Illegal code on the 5-output instance.
    b_en_n = 1'b0; b_sel = 3'd6;
    @(negedge clk);
    chk("B.illegal_y", int'(b_y), 5'h1F);
    chk("B.illegal_idx", int'(b_idx), 6);
    b_sel = 3'd4;
    @(negedge clk);
    chk("B.sel4", int'(b_y), 5'b01111);

    // Scan with dwell 3 and one blank cycle: 16-cycle period.
    a_en_n = 1'b0; a_mode = 1'b0; a_sel = 2'd0;
    @(negedge clk);
    a_mode = 1'b1; a_dwell = 8'd3;
    for (int i = 0; i < 17; i++) begin
      chk("A.scan_y", int'(a_y), int'(scan4[i]));
      chk("A.scan_wrap", int'(a_wrap), (i == 16) ? 1 : 0);
      @(negedge clk);
    end

    // Freeze after the second cycle of idx 2 with dwell 4.
    a_mode = 1'b0; a_sel = 2'd2;
    @(negedge clk);
    a_mode = 1'b1; a_dwell = 8'd4;
    @(negedge clk);
    chk("A.frz_pre", int'(a_y), 4'b1011);
    a_en_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("A.frozen", int'(a_y), 4'hF);
    end
    a_en_n = 1'b0;
    @(negedge clk); chk("A.resume1", int'(a_y), 4'b1011);
    @(negedge clk); chk("A.resume2", int'(a_y), 4'b1011);
    @(negedge clk); chk("A.resume_gap", int'(a_y), 4'hF);
    @(negedge clk); chk("A.resume_next", int'(a_y), 4'b0111);

    // No blank, dwell 0 then dwell 1: advance every cycle, wrap every 5th.
    for (int dw = 0; dw < 2; dw++) begin
      b_mode = 1'b0; b_sel = 3'd0; b_dwell = 4'(dw);
      @(negedge clk);
      b_mode = 1'b1;
      for (int i = 0; i < 11; i++) begin
        chk("B.fast_y", int'(b_y), int'(scan5[i % 5]));
        chk("B.fast_wrap", int'(b_wrap), (i > 0 && i % 5 == 0) ? 1 : 0);
        @(negedge clk);
      end
    end

    // Scan from an illegal index must wrap to 0 on the first advance.
    b_mode = 1'b0; b_sel = 3'd7; b_dwell = 4'd1;
    @(negedge clk);
    b_mode = 1'b1;
    @(negedge clk);
    chk("B.illegal_wrap", int'(b_wrap), 1);
    chk("B.illegal_to0", int'(b_y), 5'b11110);

    // Randomized traffic on both instances.
    for (int c = 0; c < 3000; c++) begin
      a_en_n = ($urandom_range(0, 7) == 0);
      b_en_n = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 19) == 0) a_mode = ~a_mode;
      if ($urandom_range(0, 19) == 0) b_mode = ~b_mode;
      a_sel = 2'($urandom);
      b_sel = 3'($urandom);
      if ($urandom_range(0, 9) == 0) a_dwell = 8'($urandom_range(0, 5));
      if ($urandom_range(0, 9) == 0) b_dwell = 4'($urandom_range(0, 4));
      if (c == 1500) begin
        a_mode = 1'b1; b_mode = 1'b1; a_en_n = 1'b0; b_en_n = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("A.async_y", int'(a_y), 4'hF);
        chk("A.async_idx", int'(a_idx), 0);
        chk("A.async_wrap", int'(a_wrap), 0);
        chk("B.async_y", int'(b_y), 5'h1F);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
      end
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
